// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared constants for the programmable countdown timer.
// Register offsets (bridge address bits [3:2]), FSM state encodings,
// mode encodings and CTRL bit positions used by RTL and bench alike.
package timer_counter_pkg;

  // Register word offsets
  localparam logic [1:0] TMR_CTRL     = 2'd0;
  localparam logic [1:0] TMR_PRESET   = 2'd1;
  localparam logic [1:0] TMR_COUNT    = 2'd2;
  localparam logic [1:0] TMR_PRESCALE = 2'd3;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  // CTRL.MODE encodings
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL bit positions; only the low CTRL_W bits are implemented
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: data-memory bus slice between the system bridge and the timer.
// Ports: Addr (word offset), WE (decoded write enable), Din (store data),
//        Dout (combinational read data), IRQ (level interrupt to the core).
interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  // Bridge / CPU side
  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  // Timer side
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter_prescaler.sv
// timer_counter_prescaler: divides the count rate; tick is high while the
// internal counter equals PRESCALE, after which the counter wraps to 0.
// Ports: clk, reset, clr (force counter to 0), run (advance), prescale, tick.
// Present only in builds with TIMER_PRESCALE_EN defined.
`ifdef TIMER_PRESCALE_EN
module timer_counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (run)   cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer with one-shot / auto-reload modes.
// Ports: clk, reset (sync, active-high), bus (timer_counter_if.slave: Addr/WE/Din
//        in, Dout combinational read, IRQ level = irq_flag & CTRL.IM).
// Optional build macro TIMER_PRESCALE_EN adds the PRESCALE register at offset 3.
module timer_counter
  import timer_counter_pkg::*;
`ifdef TIMER_PRESCALE_EN
#(
  parameter int PRESCALE_W = 8
)
`endif
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              irq_q,   irq_d;
  logic              tick;
  logic [1:0]        mode_eff;

  // MODE 10/11 are treated as one-shot
  assign mode_eff = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) ? MODE_RELOAD
                                                                        : MODE_ONESHOT;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  timer_counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      ((state_q == S_IDLE) || (state_q == S_LOAD)),
    .run      ((state_q == S_CNT) && ctrl_q[CTRL_EN]),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;
`ifdef TIMER_PRESCALE_EN
    prescale_d = prescale_q;
`endif

    case (state_q)
      S_IDLE: if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = S_IDLE;              // COUNT is frozen where it stopped
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin                 // PRESET=0 lands here too, same as 1
            count_d = '0;
            irq_d   = 1'b1;
            state_d = S_INT;
          end
        end
      end
      S_INT: begin
        if (mode_eff == MODE_RELOAD) irq_d = 1'b0;   // 1-cycle pulse, EN stays set
        else                         ctrl_d[CTRL_EN] = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes are applied last so they override the hardware EN clear
    if (bus.WE) begin
      case (bus.Addr)
        TMR_CTRL: begin
          ctrl_d = bus.Din[CTRL_W-1:0];
          irq_d  = 1'b0;
        end
        TMR_PRESET: preset_d = bus.Din;
`ifdef TIMER_PRESCALE_EN
        TMR_PRESCALE: prescale_d = bus.Din[PRESCALE_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
`endif
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      TMR_CTRL:     bus.Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
      TMR_PRESET:   bus.Dout = preset_q;
      TMR_COUNT:    bus.Dout = count_q;
`ifdef TIMER_PRESCALE_EN
      TMR_PRESCALE: bus.Dout = {{(32-PRESCALE_W){1'b0}}, prescale_q};
`else
      TMR_PRESCALE: bus.Dout = '0;
`endif
      default:      bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irq_q & ctrl_q[CTRL_IM];

endmodule
